// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the read-port source selector for regfile.
//
// Contents:
//   RstEnable / RstDisable   - levels of the active-low reset
//   WriteEnable, ReadEnable  - asserted levels of the write/read enables
//   rd_src_e                 - where a read port takes its value from
//   read_src()               - priority resolution for one read port
//
// Configuration: REGFILE_BYPASS_EN (used by regfile.sv) enables same-cycle
// write-to-read forwarding.
package regfile_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic RstDisable  = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_FWD  = 2'd1,
    SRC_GPR  = 2'd2
  } rd_src_e;

  // Reset dominates, then the port enable, then r0, then forwarding.
  function automatic rd_src_e read_src(input logic rst_lvl,
                                       input logic re,
                                       input logic addr_zero,
                                       input logic hit);
    if (rst_lvl == RstEnable)  return SRC_ZERO;
    if (re != ReadEnable)      return SRC_ZERO;
    if (addr_zero)             return SRC_ZERO;
    if (hit)                   return SRC_FWD;
    return SRC_GPR;
  endfunction

endpackage

// File: rtl/regfile_hilo_reg.sv
// hilo_reg: HI/LO register pair written together from the write-back stage.
//
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-low reset, clears HI and LO
//   we     in  HI/LO write enable (wb_whilo)
//   hi_i   in  HI write data
//   lo_i   in  LO write data
//   hi_o   out stored HI
//   lo_o   out stored LO
module hilo_reg
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  // HI and LO always move as a pair; reset beats a coincident write.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (we == WriteEnable) begin
      hi_o <= hi_i;
      lo_o <= lo_i;
    end
  end

endmodule

// File: rtl/regfile.sv
// regfile: 32x32 general-purpose register file plus HI/LO pair, written by
// the MEM/WB bundle and read combinationally by decode.
//
// Ports:
//   clk            in  rising-edge clock
//   rst            in  synchronous active-low reset (clears GPRs, HI, LO;
//                      forces both read ports to 0 while low)
//   we/waddr/wdata in  GPR write port (writes to r0 are dropped)
//   re1/raddr1     in  read port 1 enable/address;  rdata1 out
//   re2/raddr2     in  read port 2 enable/address;  rdata2 out
//   whilo          in  HI/LO write enable
//   hi_i/lo_i      in  HI/LO write data
//   hi_o/lo_o      out stored HI/LO (never forwarded)
//
// Configuration: define REGFILE_BYPASS_EN to return wdata on a read port in
// the same cycle a matching write is presented. Undefined, reads see stored
// contents only and a write becomes visible one cycle later.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] gpr [REG_NUM];
  logic              hit1;
  logic              hit2;
  rd_src_e           src1;
  rd_src_e           src2;

  // Reset clears every entry and wins over a coincident write.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr[i] <= '0;
      end
    end else if ((we == WriteEnable) && (waddr != '0)) begin
      gpr[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // r0 and reset are excluded later by read_src priority.
  assign hit1 = (we == WriteEnable) && (waddr == raddr1);
  assign hit2 = (we == WriteEnable) && (waddr == raddr2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign src1 = read_src(rst, re1, (raddr1 == '0), hit1);
  assign src2 = read_src(rst, re2, (raddr2 == '0), hit2);

  always_comb begin
    rdata1 = '0;
    unique case (src1)
      SRC_FWD: rdata1 = wdata;
      SRC_GPR: rdata1 = gpr[raddr1];
      default: rdata1 = '0;
    endcase
  end

  always_comb begin
    rdata2 = '0;
    unique case (src2)
      SRC_FWD: rdata2 = wdata;
      SRC_GPR: rdata2 = gpr[raddr2];
      default: rdata2 = '0;
    endcase
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (whilo),
    .hi_i (hi_i),
    .lo_i (lo_i),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed bench for regfile. Expected values are queued when a
// step is driven and popped when the corresponding output is sampled.
module tb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic          whilo;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .REG_NUM (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .whilo  (whilo),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [DW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [DW-1:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance past a rising edge; inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] fwd_exp;

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    whilo = 1'b0; hi_i = '0; lo_i = '0;

    // Read ports forced to 0 while reset is held
    #1;
    push("rst_rd1", '0); push("rst_rd2", '0);
    compare(rdata1); compare(rdata2);
    tick();
    tick();
    rst = 1'b1;
    #1;

    // All registers read 0 after reset, on both ports
    for (int i = 0; i < 32; i++) begin
      raddr1 = AW'(i);
      raddr2 = AW'(31 - i);
      #1;
      push($sformatf("reset_p1_r%0d", i), '0);
      push($sformatf("reset_p2_r%0d", 31 - i), '0);
      compare(rdata1);
      compare(rdata2);
    end
    push("reset_hi", '0); push("reset_lo", '0);
    compare(hi_o); compare(lo_o);

    // Write r5, read it next cycle; disabled port reads 0
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; re1 = 1'b1; raddr2 = 5'd6;
    #1;
    push("wr_r5_p1", 32'hDEADBEEF); push("rd_r6_p2", '0);
    compare(rdata1); compare(rdata2);
    re1 = 1'b0;
    #1;
    push("re1_off", '0);
    compare(rdata1);
    re1 = 1'b1;

    // r0 protection, including no forwarding of an r0 write
    we = 1'b1; waddr = '0; wdata = 32'hFFFFFFFF; raddr1 = '0; raddr2 = '0;
    #1;
    push("r0_wr_p1", '0); push("r0_wr_p2", '0);
    compare(rdata1); compare(rdata2);
    tick();
    we = 1'b0;
    #1;
    push("r0_p1", '0); push("r0_p2", '0);
    compare(rdata1); compare(rdata2);

    // Forwarding: r7 holds an old value, new write presented with reads of r7
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    tick();
    wdata = 32'h12345678; raddr1 = 5'd7; raddr2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    fwd_exp = 32'h12345678;
`else
    fwd_exp = 32'h11111111;
`endif
    #1;
    push("fwd_same_p1", fwd_exp); push("fwd_same_p2", fwd_exp);
    compare(rdata1); compare(rdata2);
    re2 = 1'b0;
    #1;
    push("fwd_re2_off", '0);
    compare(rdata2);
    re2 = 1'b1;
    tick();
    we = 1'b0; wdata = '0;
    #1;
    push("fwd_next_p1", 32'h12345678); push("fwd_next_p2", 32'h12345678);
    compare(rdata1); compare(rdata2);

    // Ports resolve independently
    raddr1 = 5'd5; raddr2 = 5'd7;
    #1;
    push("indep_p1", 32'hDEADBEEF); push("indep_p2", 32'h12345678);
    compare(rdata1); compare(rdata2);

    // HI/LO: no change before the edge, update after it, hold with whilo=0
    whilo = 1'b1; hi_i = 32'hAAAA0000; lo_i = 32'h0000BBBB;
    #1;
    push("hilo_pre_hi", '0); push("hilo_pre_lo", '0);
    compare(hi_o); compare(lo_o);
    tick();
    whilo = 1'b0;
    #1;
    push("hilo_wr_hi", 32'hAAAA0000); push("hilo_wr_lo", 32'h0000BBBB);
    compare(hi_o); compare(lo_o);
    hi_i = 32'h00000001; lo_i = 32'h00000002;
    tick();
    push("hilo_hold_hi", 32'hAAAA0000); push("hilo_hold_lo", 32'h0000BBBB);
    compare(hi_o); compare(lo_o);

    // Reset beats simultaneous GPR and HI/LO writes
    rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h00000055;
    whilo = 1'b1; hi_i = 32'h0000CAFE; lo_i = 32'h0000F00D;
    raddr1 = 5'd5; raddr2 = 5'd7;
    #1;
    push("rst_mid_p1", '0); push("rst_mid_hi", 32'hAAAA0000);
    compare(rdata1); compare(hi_o);
    tick();
    rst = 1'b1; we = 1'b0; whilo = 1'b0;
    raddr1 = 5'd3; raddr2 = 5'd5;
    #1;
    push("rstwr_r3", '0); push("rstwr_r5", '0);
    compare(rdata1); compare(rdata2);
    raddr1 = 5'd7;
    #1;
    push("rstwr_r7", '0);
    compare(rdata1);
    push("rstwr_hi", '0); push("rstwr_lo", '0);
    compare(hi_o); compare(lo_o);

    // Every queued expectation must have been consumed
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural state sink at the far end of the MEM/WB pipeline register. It holds the 32×32 general-purpose register file and the HI/LO pair. Its single write port and the HI/LO write port consume the write-back bundle (`wb_wd`/`wb_wdata`/`wb_wreg`, `wb_hi`/`wb_lo`/`wb_whilo`). Its two read ports serve the decode stage, with optional same-cycle write-to-read forwarding.

## Interface
Parameters:
- DATA_W, 32, register and HI/LO width
- ADDR_W, 5, register address width
- REG_NUM, 32, number of GPRs (2**ADDR_W)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- we  in  1  GPR write enable (driven by wb_wreg)
- waddr  in  ADDR_W  GPR write address (wb_wd)
- wdata  in  DATA_W  GPR write data (wb_wdata)
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data
- whilo  in  1  HI/LO write enable (wb_whilo)
- hi_i  in  DATA_W  HI write data (wb_hi)
- lo_i  in  DATA_W  LO write data (wb_lo)
- hi_o  out  DATA_W  current HI
- lo_o  out  DATA_W  current LO

## Operation
- Reset (rst = 0 at a rising edge): all 32 GPRs, HI and LO are cleared to 0.
- Read ports while rst = 0: rdata1 and rdata2 are forced to 0.
- GPR write: on a rising edge with rst = 1, we = 1 and waddr ≠ 0, the block sets GPR[waddr] ← wdata.
- Writes to r0 are discarded; r0 always reads 0.
- HI/LO write: on a rising edge with rst = 1 and whilo = 1, the block sets HI ← hi_i and LO ← lo_i together. HI and LO are never written separately.
- Read port n is combinational, evaluated in priority order:
  - rst = 0 → 0
  - re_n = 0 → 0
  - raddr_n = 0 → 0
  - forwarding hit (see Configuration) → wdata
  - otherwise → GPR[raddr_n]
- Both read ports may address the same register, including the register being written; each port resolves independently.
- hi_o/lo_o reflect the stored HI/LO values only. The block does not forward HI/LO; the EX stage handles HI/LO forwarding.
- No stall input: the write-back stage never stalls, so every enabled write commits on the edge where it is presented.

## Timing
- Write latency: 1 cycle. A write presented in cycle N is visible from stored state in cycle N+1.
- Read latency: 0 cycles, combinational from raddr/re/rst and, with forwarding, from we/waddr/wdata.
- Reset is sampled only at rising edges; asserting rst mid-cycle does not alter the stored state until the next edge.
- Reset has priority over a simultaneous write: the write is lost.
- Reset values of all outputs: rdata1 = rdata2 = 0 during reset; hi_o = lo_o = 0 after the reset edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read port hits when rst = 1, re_n = 1, we = 1, waddr = raddr_n and raddr_n ≠ 0.
  - On a hit, the port returns wdata in the same cycle, so decode sees the instruction currently in WB.
- REGFILE_BYPASS_EN undefined:
  - Read ports return stored contents only; a same-cycle write is seen one cycle later.
  - The decode stage then relies on its own MEM/WB-result forwarding.

## Structure
- Shared constants live in defines.v, not locally: RegBus, RegAddrBus, RegNum, ZeroWord, NOPRegAddr, RstEnable/RstDisable, WriteEnable, ReadEnable/ReadDisable.
- One natural sub-module: hilo_reg, containing the HI/LO pair, its synchronous active-low reset and the whilo write. It is instantiated inside regfile.
- The GPR array, write logic and read muxes stay in the top module.

## Test plan
- Reset: hold rst = 0 for 2 edges, then release. Read all 32 registers on both ports with re = 1 → all 0; hi_o = lo_o = 0.
- Write/read: write r5 = 0xDEADBEEF, then read on port1 next cycle → 0xDEADBEEF. Same read with re1 = 0 → 0.
- r0 protection: we = 1, waddr = 0, wdata = 0xFFFFFFFF; next cycle read r0 on both ports → 0.
- Forwarding: in one cycle, write r7 = 0x12345678 and read raddr1 = raddr2 = 7.
  - With REGFILE_BYPASS_EN: both ports → 0x12345678 in that cycle.
  - Without: both ports → previous r7 value, then 0x12345678 next cycle.
- HI/LO: whilo = 1, hi_i = 0xAAAA0000, lo_i = 0x0000BBBB → hi_o/lo_o update after 1 edge. With whilo = 0 and new inputs → values unchanged.
- Reset vs. write: rst = 0 and we = 1 (r3 = 0x55) plus whilo = 1 on the same edge → r3, HI and LO all read 0 after release.
